// File: rtl/dbus_mem_responder_pkg.sv
// Shared types for the data-bus SRAM responder: FSM states and request capture.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package dbus_mem_responder_pkg;

    localparam int DBUS_XLEN = 32;
    localparam int DBUS_AW   = 32;
    localparam int DBUS_SW   = DBUS_XLEN / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } type_dbus_resp_state_e;

    // Capture register widths track the package XLEN/AW; the top defaults match them.
    typedef struct packed {
        logic [DBUS_AW-1:0]   addr;
        logic [DBUS_XLEN-1:0] wdata;
        logic [DBUS_SW-1:0]   sel;
        logic                 we;
    } type_dbus_req_s;

endpackage

// File: rtl/dbus_addr_decode.sv
// Range check of a byte address against the SRAM window and its word index.
// Latency: combinational.
// Backpressure: none.
module dbus_addr_decode #(
    parameter int                    ADDR_WIDTH      = 32,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE        = 32'h8000_0000,
    parameter int                    MEM_DEPTH_WORDS = 4096,
    parameter int                    MEM_AW          = 12
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  in_range,
    output logic [MEM_AW-1:0]     word_idx
);

    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_DEPTH_WORDS * 4);

    logic [ADDR_WIDTH-1:0] offset;

    // Unsigned wrap makes addresses below MEM_BASE look huge, so one compare covers both ends.
    assign offset   = addr - MEM_BASE;
    assign in_range = (offset < MEM_BYTES);
    assign word_idx = offset[MEM_AW+1:2];

endmodule

// File: rtl/dbus_mem_responder.sv
// Data-bus slave answering one load/store at a time from a byte-enabled sync SRAM.
// Latency: ack 1 cycle after capture on error, 2+WRITE_WAIT for stores, 2+READ_LATENCY for loads.
// Backpressure: none; requester holds req and fields until the one-cycle ack.
module dbus_mem_responder
    import dbus_mem_responder_pkg::*;
#(
    parameter int                    DATA_WIDTH      = DBUS_XLEN,
    parameter int                    ADDR_WIDTH      = DBUS_AW,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE        = 32'h8000_0000,
    parameter int                    MEM_DEPTH_WORDS = 4096,
    parameter int                    READ_LATENCY    = 1,
    parameter int                    WRITE_WAIT      = 0,
    localparam int                   MEM_AW          = $clog2(MEM_DEPTH_WORDS),
    localparam int                   SEL_W           = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dbus_req_i,
    input  logic [ADDR_WIDTH-1:0] dbus_addr_i,
    input  logic [DATA_WIDTH-1:0] dbus_wdata_i,
    input  logic [SEL_W-1:0]      dbus_sel_i,
    input  logic                  dbus_we_i,
    output logic [DATA_WIDTH-1:0] dbus_rdata_o,
    output logic                  dbus_ack_o,
    output logic                  dbus_err_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [SEL_W-1:0]      mem_be_o,
    output logic [MEM_AW-1:0]     mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam logic [2:0] RD_CNT = 3'(READ_LATENCY - 1);
    localparam logic [2:0] WR_CNT = (WRITE_WAIT > 0) ? 3'(WRITE_WAIT - 1) : 3'd0;

    type_dbus_resp_state_e state_q, state_d;
    type_dbus_req_s        req_q;
    logic                  err_q;
    logic [2:0]            cnt_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic [ADDR_WIDTH-1:0] dec_addr;
    logic                  in_range;
    logic [MEM_AW-1:0]     word_idx;

    // Decode the live bus address while idle, the captured one afterwards.
    assign dec_addr = (state_q == IDLE) ? dbus_addr_i : req_q.addr;

    dbus_addr_decode #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .MEM_BASE       (MEM_BASE),
        .MEM_DEPTH_WORDS(MEM_DEPTH_WORDS),
        .MEM_AW         (MEM_AW)
    ) u_addr_decode (
        .addr    (dec_addr),
        .in_range(in_range),
        .word_idx(word_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (dbus_req_i) state_d = in_range ? ACCESS : RESP;
            ACCESS:  state_d = (req_q.we && (WRITE_WAIT == 0)) ? RESP : WAIT;
            WAIT:    if (cnt_q == 3'd0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        dbus_ack_o  = 1'b0;
        dbus_err_o  = 1'b0;
        case (state_q)
            ACCESS: begin
                mem_en_o    = 1'b1;
                mem_we_o    = req_q.we;
                mem_be_o    = req_q.we ? req_q.sel : '0;
                mem_addr_o  = word_idx;
                mem_wdata_o = req_q.wdata;
            end
            RESP: begin
                dbus_ack_o = 1'b1;
                dbus_err_o = err_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= 3'd0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dbus_req_i) begin
                        req_q <= '{addr: dbus_addr_i, wdata: dbus_wdata_i,
                                   sel: dbus_sel_i, we: dbus_we_i};
                        err_q <= ~in_range;
                        if (!in_range) rdata_q <= '0;
                    end
                end
                ACCESS: cnt_q <= req_q.we ? WR_CNT : RD_CNT;
                WAIT: begin
                    // The counter's last cycle lines up with SRAM read data being valid.
                    if (cnt_q == 3'd0) begin
                        if (!req_q.we) rdata_q <= mem_rdata_i;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dbus_rdata_o = rdata_q;

endmodule
